// File: rtl/state_machine.sv
// Round sequencer for the expanded DES key schedule: one LOAD cycle followed by ROUNDS round cycles.
// Optional macro STATE_MACHINE_ONE_SHOT_EN parks the sequencer in LOAD after the first schedule.
module state_machine #(
  parameter int unsigned ROUNDS = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  output logic       Select_mux_pc_temp,
  output logic       Select_mux_shift_temp,
  output logic [4:0] Counter,
  output logic       Pre_state,
  output logic       Next_state
);

  typedef enum logic {
    LOAD  = 1'b0,
    ROUND = 1'b1
  } state_t;

  localparam logic [4:0] RoundsC = 5'(ROUNDS);

  state_t     state_q, state_d;
  logic [4:0] counter_q, counter_d;

`ifdef STATE_MACHINE_ONE_SHOT_EN
  logic done_q, done_d;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= LOAD;
      counter_q <= 5'd0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
    end
  end

  // An out-of-range counter can only come from corruption; it always recovers to LOAD/0.
  always_comb begin
    state_d   = LOAD;
    counter_d = 5'd0;
`ifdef STATE_MACHINE_ONE_SHOT_EN
    done_d    = done_q;
`endif
    if (counter_q > RoundsC) begin
      state_d   = LOAD;
      counter_d = 5'd0;
    end else begin
      unique case (state_q)
        LOAD: begin
`ifdef STATE_MACHINE_ONE_SHOT_EN
          if (done_q) begin
            state_d   = LOAD;
            counter_d = 5'd0;
          end else begin
            state_d   = ROUND;
            counter_d = 5'd1;
          end
`else
          state_d   = ROUND;
          counter_d = 5'd1;
`endif
        end
        ROUND: begin
          if (counter_q < RoundsC) begin
            state_d   = ROUND;
            counter_d = counter_q + 5'd1;
          end else begin
            state_d   = LOAD;
            counter_d = 5'd0;
`ifdef STATE_MACHINE_ONE_SHOT_EN
            done_d    = 1'b1;
`endif
          end
        end
        default: begin
          state_d   = LOAD;
          counter_d = 5'd0;
        end
      endcase
    end
  end

  always_comb begin
    Pre_state             = state_q;
    Next_state            = state_d;
    Counter               = counter_q;
    Select_mux_pc_temp    = ~state_q;
    Select_mux_shift_temp = 1'b0;
    if (state_q == ROUND) begin
      Select_mux_shift_temp = (counter_q == 5'd1) || (counter_q == 5'd2) ||
                              (counter_q == 5'd9) || (counter_q == RoundsC);
    end
  end

endmodule

// File: tb/tb_state_machine.sv
// Scoreboard bench for the DES key-schedule round sequencer: directed reset/run steps,
// expected outputs queued from a small reference model and popped after each edge.
module tb_state_machine;

  localparam int Rounds = 16;

  logic       clock;
  logic       reset;
  logic       selPc;
  logic       selShift;
  logic [4:0] counter;
  logic       preState;
  logic       nextState;

  typedef struct {
    string      tag;
    logic [4:0] cnt;
    logic       pre;
    logic       next;
    logic       pc;
    logic       shift;
  } expect_t;

  expect_t scoreboard[$];
  int      assertCount = 0;
  int      failCount = 0;
  int      modelCnt = 0;
  bit      modelDone = 1'b0;

  state_machine #(.ROUNDS(Rounds)) dut (
    .Clk                   (clock),
    .Reset                 (reset),
    .Select_mux_pc_temp    (selPc),
    .Select_mux_shift_temp (selShift),
    .Counter               (counter),
    .Pre_state             (preState),
    .Next_state            (nextState)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected outputs follow directly from the model round number and the parked flag.
  function automatic void pushExpected(input string tag);
    expect_t e;
    e.tag   = tag;
    e.cnt   = 5'(modelCnt);
    e.pre   = (modelCnt != 0);
    e.next  = modelDone ? 1'b0 : (modelCnt != Rounds);
    e.pc    = (modelCnt == 0);
    e.shift = (modelCnt == 1) || (modelCnt == 2) || (modelCnt == 9) || (modelCnt == Rounds);
    scoreboard.push_back(e);
  endfunction

  function automatic void advanceModel();
    if (modelDone) begin
      modelCnt = 0;
    end else if (modelCnt == Rounds) begin
      modelCnt = 0;
`ifdef STATE_MACHINE_ONE_SHOT_EN
      modelDone = 1'b1;
`endif
    end else begin
      modelCnt = modelCnt + 1;
    end
  endfunction

  function automatic void resetModel();
    modelCnt  = 0;
    modelDone = 1'b0;
  endfunction

  task automatic checkField(input string tag, input string field, input logic [4:0] obs,
                            input logic [4:0] exp);
    assertCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s/%s observed=%0d expected=%0d", tag, field, obs, exp);
    end
  endtask

  task automatic checkOutput();
    expect_t e;
    if (scoreboard.size() == 0) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL scoreboard_empty observed=0 expected=1 entries");
    end else begin
      e = scoreboard.pop_front();
      checkField(e.tag, "Counter", counter, e.cnt);
      checkField(e.tag, "Pre_state", {4'd0, preState}, {4'd0, e.pre});
      checkField(e.tag, "Next_state", {4'd0, nextState}, {4'd0, e.next});
      checkField(e.tag, "Select_mux_pc_temp", {4'd0, selPc}, {4'd0, e.pc});
      checkField(e.tag, "Select_mux_shift_temp", {4'd0, selShift}, {4'd0, e.shift});
    end
  endtask

  task automatic applyStimulus(input string tag);
    @(posedge clock);
    advanceModel();
    pushExpected(tag);
    #1;
    checkOutput();
  endtask

  // Asserts reset away from any edge, checks the asynchronous effect, then releases after an edge.
  task automatic applyReset(input string tag);
    @(negedge clock);
    #2;
    reset = 1'b1;
    resetModel();
    pushExpected({tag, "_async"});
    #1;
    checkOutput();
    @(posedge clock);
    #2;
    reset = 1'b0;
    pushExpected({tag, "_released"});
    checkOutput();
  endtask

  initial begin
    reset = 1'b0;

    // Asynchronous reset before any clock edge.
    #3;
    reset = 1'b1;
    resetModel();
    pushExpected("reset_async_t3");
    #1;
    checkOutput();
    @(posedge clock);
    #2;
    reset = 1'b0;
    pushExpected("reset_released");
    checkOutput();

    // One full schedule: 1..16 then back to LOAD.
    for (int i = 0; i < Rounds + 1; i++) applyStimulus($sformatf("run1_step%0d", i));

    // Abort mid-sequence at round 7, then one full schedule again.
    applyReset("pre_abort");
    for (int i = 0; i < 7; i++) applyStimulus($sformatf("to7_step%0d", i));
    #2;
    reset = 1'b1;
    resetModel();
    pushExpected("abort_at7_async");
    #1;
    checkOutput();
    @(posedge clock);
    #2;
    reset = 1'b0;
    pushExpected("abort_released");
    checkOutput();
    for (int i = 0; i < Rounds + 1; i++) applyStimulus($sformatf("run2_step%0d", i));

    // Long run: continuous cycling by default, parked LOAD in one-shot builds.
    applyReset("long");
    for (int i = 0; i < 40; i++) applyStimulus($sformatf("long_step%0d", i));
`ifdef STATE_MACHINE_ONE_SHOT_EN
    applyReset("unpark");
    for (int i = 0; i < Rounds + 1; i++) applyStimulus($sformatf("rerun_step%0d", i));
`endif

    if (scoreboard.size() != 0) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL scoreboard_leftover observed=%0d expected=0 entries", scoreboard.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
